if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  MIPS IF stage: owns PC register, issues instruction-memory fetches, loads IF/ID pipeline register.
//  Produces o_addr_pcadd4 (d0 of the IF PC mux); consumes that mux's output as i_addr_nextpc.
//  Single outstanding fetch; variable imem latency. Fetch misses become bubbles; branch redirects squash in-flight fetches.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   PC value after reset
//  AW         32              PC/address width
//  DW         32              instruction width
// PORTS
//  i_clk            in   1   clock, rising edge
//  i_rst_n          in   1   reset, asynchronous, active-low
//  i_addr_nextpc    in   AW  next PC from IF PC mux
//  i_con_PCSrc      in   1   branch taken/redirect; i_addr_nextpc is the target this cycle
//  i_con_stallF     in   1   hazard stall: hold PC and IF/ID
//  i_con_flushD     in   1   clear IF/ID to bubble
//  o_addr_pcF       out  AW  current PC
//  o_addr_pcadd4    out  AW  o_addr_pcF + 4, combinational
//  o_imem_valid     out  1   fetch request valid
//  o_imem_addr      out  AW  fetch address (= o_addr_pcF)
//  i_imem_ready     in   1   imem accepts request (handshake = valid & ready)
//  i_imem_rvalid    in   1   response valid, 1 cycle
//  i_imem_rdata     in   DW  fetched instruction
//  o_instrD         out  DW  IF/ID instruction
//  o_addr_pcplus4D  out  AW  IF/ID PC+4
//  o_validD         out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset: PC=RESET_PC, state S_REQ, o_instrD=32'h0 (NOP), o_addr_pcplus4D=0, o_validD=0, o_imem_valid=0 during reset.
//  Adder: o_addr_pcadd4 = pc + 4, modulo 2^AW (0xFFFF_FFFC -> 0x0000_0000). PC[1:0] never checked.
//  FSM states:
//   S_REQ : o_imem_valid=1. valid&ready -> S_WAIT. imem samples address only on handshake; address may change while unaccepted.
//   S_WAIT: await rvalid. rvalid & !stallF -> PC<=i_addr_nextpc, IF/ID<={rdata, pc+4, 1}, -> S_REQ.
//           rvalid & stallF -> capture into hold buffer, -> S_HOLD.
//   S_HOLD: buffered instr; when !stallF -> PC<=i_addr_nextpc, IF/ID<=buffer, -> S_REQ.
//   S_DROP: squashed fetch outstanding; rvalid discarded, -> S_REQ. PC/IF/ID unchanged by the response.
//  Redirect (i_con_PCSrc=1) overrides stallF; PC<=i_addr_nextpc in all states:
//   S_REQ no handshake -> stay S_REQ (new address presented next cycle); S_REQ with handshake same cycle -> S_DROP.
//   S_WAIT without rvalid -> S_DROP; S_WAIT with rvalid -> data discarded, -> S_REQ.
//   S_HOLD -> buffer discarded, -> S_REQ. S_DROP -> stay S_DROP.
//  IF/ID priority per cycle: flushD (load NOP, valid=0) > stallF (hold) > fetch completes (load) > else bubble (NOP, valid=0).
//  Latency: handshake to IF/ID load = 1 cycle after rvalid; back-to-back zero-wait imem gives one instr per 2 cycles.
//  rvalid outside S_WAIT/S_DROP ignored. Async reset mid-fetch abandons the fetch; imem is reset on the same i_rst_n.
// CONFIGURATION
//  IF_FETCH_STALL_CNT_EN defined: extra port o_stat_fetchstall out 32: cycles in S_WAIT/S_DROP without rvalid;
//   saturates at 32'hFFFF_FFFF; reset 0. Undefined: port and counter absent, no other change.
// STRUCTURE
//  arc_pkg: fetch_state_e {S_REQ,S_WAIT,S_HOLD,S_DROP}, NOP_INSTR=32'h0000_0000, RESET_VECTOR.
//  Sub-module if_id_reg: IF/ID register with flush>stall>load>bubble priority; instantiated once.
// TESTING
//  1 Reset release, ready=1, rvalid 1 cycle after handshake, rdata=0x2008_0005 -> first imem_addr=0xBFC0_0000; o_instrD=0x2008_0005, o_addr_pcplus4D=0xBFC0_0004, o_validD=1.
//  2 rvalid while stallF=1 for 3 cycles -> IF/ID and PC held, state S_HOLD; instr loaded the cycle after stallF drops.
//  3 PCSrc=1 with nextpc=0x0040_0100 in S_WAIT, rvalid next cycle -> response discarded, next imem_addr=0x0040_0100, o_validD stays 0.
//  4 PCSrc and rvalid same cycle in S_WAIT -> data discarded, S_REQ with target address; flushD same cycle -> o_instrD=0, o_validD=0.
//  5 PC=0xFFFF_FFFC -> o_addr_pcadd4=0x0000_0000; ready held low 5 cycles -> imem_valid stays 1, bubbles, (EN) counter unchanged in S_REQ.
//  6 i_rst_n low in S_WAIT -> outputs return to reset values asynchronously; late rvalid in S_REQ ignored.

Source files
------------

// File: rtl/arc_pkg.sv
// Shared definitions for the MIPS IF stage.
//   fetch_state_e : fetch FSM states (request / wait / hold / drop)
//   NOP_INSTR     : instruction placed in IF/ID for a bubble
//   RESET_VECTOR  : default PC after reset
package arc_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority each cycle: flush (NOP, invalid) > stall (hold) > load > bubble (NOP, invalid).
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_flush/i_stall/i_load control
//   i_instr, i_pcplus4     data to load
//   o_instr, o_pcplus4,
//   o_valid                registered IF/ID contents
module if_id_reg
  import arc_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_stall,
  input  logic          i_load,
  input  logic [DW-1:0] i_instr,
  input  logic [AW-1:0] i_pcplus4,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_pcplus4,
  output logic          o_valid
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instr   <= DW'(NOP_INSTR);
      o_pcplus4 <= '0;
      o_valid   <= 1'b0;
    end else if (i_flush) begin
      o_instr   <= DW'(NOP_INSTR);
      o_pcplus4 <= '0;
      o_valid   <= 1'b0;
    end else if (i_stall) begin
      o_instr   <= o_instr;
      o_pcplus4 <= o_pcplus4;
      o_valid   <= o_valid;
    end else if (i_load) begin
      o_instr   <= i_instr;
      o_pcplus4 <= i_pcplus4;
      o_valid   <= 1'b1;
    end else begin
      o_instr   <= DW'(NOP_INSTR);
      o_pcplus4 <= '0;
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC register, single-outstanding instruction fetch, IF/ID load.
// Optional feature macro: IF_FETCH_STALL_CNT_EN adds o_stat_fetchstall, a
// saturating count of cycles spent in S_WAIT/S_DROP without a response.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_addr_nextpc                  next PC from IF PC mux
//   i_con_PCSrc                    redirect (overrides stall)
//   i_con_stallF, i_con_flushD     hazard stall / IF/ID flush
//   o_addr_pcF, o_addr_pcadd4      current PC and PC+4
//   o_imem_valid, o_imem_addr,
//   i_imem_ready                   fetch request handshake
//   i_imem_rvalid, i_imem_rdata    one-cycle fetch response
//   o_instrD, o_addr_pcplus4D,
//   o_validD                       IF/ID register
module if_fetch_unit
  import arc_pkg::*;
#(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = AW'(RESET_VECTOR)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_addr_nextpc,
  input  logic          i_con_PCSrc,
  input  logic          i_con_stallF,
  input  logic          i_con_flushD,
  output logic [AW-1:0] o_addr_pcF,
  output logic [AW-1:0] o_addr_pcadd4,
  output logic          o_imem_valid,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_ready,
  input  logic          i_imem_rvalid,
  input  logic [DW-1:0] i_imem_rdata,
  output logic [DW-1:0] o_instrD,
  output logic [AW-1:0] o_addr_pcplus4D,
  output logic          o_validD
`ifdef IF_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]   o_stat_fetchstall
`endif
);

  fetch_state_e  state_q, state_n;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] hold_instr_q;
  logic [AW-1:0] hold_pc4_q;

  logic          pc_load;
  logic          hold_cap;
  logic          ifid_load;
  logic [DW-1:0] ifid_instr;
  logic [AW-1:0] ifid_pc4;
  logic          handshake;

  assign o_addr_pcF    = pc_q;
  assign o_addr_pcadd4 = pc_q + AW'(4);
  assign o_imem_addr   = pc_q;
  assign o_imem_valid  = (state_q == S_REQ) && i_rst_n;
  assign handshake     = (state_q == S_REQ) && i_imem_ready;

  always_comb begin
    state_n    = state_q;
    pc_load    = 1'b0;
    hold_cap   = 1'b0;
    ifid_load  = 1'b0;
    ifid_instr = i_imem_rdata;
    ifid_pc4   = o_addr_pcadd4;
    unique case (state_q)
      S_REQ: begin
        if (i_con_PCSrc) pc_load = 1'b1;
        if (handshake) state_n = i_con_PCSrc ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (i_con_PCSrc) begin
          pc_load = 1'b1;
          state_n = i_imem_rvalid ? S_REQ : S_DROP;
        end else if (i_imem_rvalid) begin
          if (i_con_stallF) begin
            hold_cap = 1'b1;
            state_n  = S_HOLD;
          end else begin
            pc_load   = 1'b1;
            ifid_load = 1'b1;
            state_n   = S_REQ;
          end
        end
      end
      S_HOLD: begin
        ifid_instr = hold_instr_q;
        ifid_pc4   = hold_pc4_q;
        if (i_con_PCSrc) begin
          pc_load = 1'b1;
          state_n = S_REQ;
        end else if (!i_con_stallF) begin
          pc_load   = 1'b1;
          ifid_load = 1'b1;
          state_n   = S_REQ;
        end
      end
      S_DROP: begin
        // A redirect here only retargets the PC; the squashed response still
        // has to drain before a new request may be issued.
        if (i_con_PCSrc) pc_load = 1'b1;
        if (i_imem_rvalid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q <= state_n;
      if (pc_load) pc_q <= i_addr_nextpc;
      if (hold_cap) begin
        hold_instr_q <= i_imem_rdata;
        hold_pc4_q   <= o_addr_pcadd4;
      end
    end
  end

  if_id_reg #(
    .AW (AW),
    .DW (DW)
  ) u_if_id_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_con_flushD),
    .i_stall   (i_con_stallF),
    .i_load    (ifid_load),
    .i_instr   (ifid_instr),
    .i_pcplus4 (ifid_pc4),
    .o_instr   (o_instrD),
    .o_pcplus4 (o_addr_pcplus4D),
    .o_valid   (o_validD)
  );

`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_WAIT || state_q == S_DROP) && !i_imem_rvalid
                 && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stat_fetchstall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import arc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] nextpc;
  logic [31:0] target;
  logic        pcsrc;
  logic        stallf;
  logic        flushd;
  logic [31:0] pcf;
  logic [31:0] pcadd4;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrd;
  logic [31:0] pcplus4d;
  logic        validd;
`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] stat_cnt;
`endif

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  // Bench plays the IF PC mux: redirect target when PCSrc, else PC+4.
  assign nextpc = pcsrc ? target : pcadd4;

  if_fetch_unit #(
    .AW       (32),
    .DW       (32),
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_addr_nextpc   (nextpc),
    .i_con_PCSrc     (pcsrc),
    .i_con_stallF    (stallf),
    .i_con_flushD    (flushd),
    .o_addr_pcF      (pcf),
    .o_addr_pcadd4   (pcadd4),
    .o_imem_valid    (imem_valid),
    .o_imem_addr     (imem_addr),
    .i_imem_ready    (imem_ready),
    .i_imem_rvalid   (imem_rvalid),
    .i_imem_rdata    (imem_rdata),
    .o_instrD        (instrd),
    .o_addr_pcplus4D (pcplus4d),
    .o_validD        (validd)
`ifdef IF_FETCH_STALL_CNT_EN
    ,
    .o_stat_fetchstall (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; target = '0; pcsrc = 0; stallf = 0; flushd = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    tick(); tick();

    // Reset values
    chk("rst_pc",      pcf,        32'hBFC0_0000);
    chk("rst_ivalid",  {31'b0, imem_valid}, 32'd0);
    chk("rst_instrD",  instrd,     32'h0);
    chk("rst_pc4D",    pcplus4d,   32'h0);
    chk("rst_validD",  {31'b0, validd}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_req_valid", {31'b0, imem_valid}, 32'd1);
    chk("t1_req_addr",  imem_addr,  32'hBFC0_0000);

    // Test 1: first fetch, zero-wait imem
    imem_ready = 1;
    tick();                                   // handshake -> S_WAIT
    chk("t1_wait_ivalid", {31'b0, imem_valid}, 32'd0);
    imem_rvalid = 1; imem_rdata = 32'h2008_0005;
    tick();                                   // load IF/ID
    imem_rvalid = 0;
    chk("t1_instrD",  instrd,   32'h2008_0005);
    chk("t1_pc4D",    pcplus4d, 32'hBFC0_0004);
    chk("t1_validD",  {31'b0, validd}, 32'd1);
    chk("t1_pc",      pcf,      32'hBFC0_0004);

    // Test 2: response arrives during stall
    stallf = 1;
    tick();                                   // handshake, IF/ID held
    chk("t2_held_instr", instrd, 32'h2008_0005);
    imem_rvalid = 1; imem_rdata = 32'h8C09_0004;
    tick();                                   // captured into hold buffer
    imem_rvalid = 0;
    chk("t2_state_hold", 32'(dut.state_q), 32'(S_HOLD));
    tick(); tick();
    chk("t2_pc_held",    pcf,    32'hBFC0_0004);
    chk("t2_instr_held", instrd, 32'h2008_0005);
    chk("t2_still_hold", 32'(dut.state_q), 32'(S_HOLD));
    stallf = 0;
    tick();
    chk("t2_instrD", instrd,   32'h8C09_0004);
    chk("t2_pc4D",   pcplus4d, 32'hBFC0_0008);
    chk("t2_validD", {31'b0, validd}, 32'd1);
    chk("t2_pc",     pcf,      32'hBFC0_0008);

    // Test 3: redirect while waiting, squashed response
    tick();                                   // handshake -> S_WAIT, bubble
    chk("t3_bubble", {31'b0, validd}, 32'd0);
    pcsrc = 1; target = 32'h0040_0100;
    tick();                                   // -> S_DROP
    pcsrc = 0;
    chk("t3_pc",        pcf, 32'h0040_0100);
    chk("t3_drop_ivld", {31'b0, imem_valid}, 32'd0);
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();                                   // discarded -> S_REQ
    imem_rvalid = 0;
    chk("t3_validD", {31'b0, validd}, 32'd0);
    chk("t3_instrD", instrd, 32'h0);
    chk("t3_addr",   imem_addr, 32'h0040_0100);
    chk("t3_ivalid", {31'b0, imem_valid}, 32'd1);
`ifdef IF_FETCH_STALL_CNT_EN
    chk("t3_cnt", stat_cnt, 32'd1);
`endif

    // Test 4: redirect + rvalid + flush in the same cycle
    tick();                                   // handshake -> S_WAIT
    imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    pcsrc = 1; target = 32'h0040_0200; flushd = 1;
    tick();
    imem_rvalid = 0; pcsrc = 0; flushd = 0;
    chk("t4_pc",     pcf,       32'h0040_0200);
    chk("t4_addr",   imem_addr, 32'h0040_0200);
    chk("t4_ivalid", {31'b0, imem_valid}, 32'd1);
    chk("t4_instrD", instrd,    32'h0);
    chk("t4_validD", {31'b0, validd}, 32'd0);

    // Test 5: PC wrap and imem not ready
    imem_ready = 0; pcsrc = 1; target = 32'hFFFF_FFFC;
    tick();                                   // redirect in S_REQ, no handshake
    pcsrc = 0;
    chk("t5_pc",    pcf,    32'hFFFF_FFFC);
    chk("t5_add4",  pcadd4, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_ivalid", {31'b0, imem_valid}, 32'd1);
      chk("t5_addr",   imem_addr, 32'hFFFF_FFFC);
      chk("t5_bubble", {31'b0, validd}, 32'd0);
    end
`ifdef IF_FETCH_STALL_CNT_EN
    chk("t5_cnt", stat_cnt, 32'd1);
`endif
    imem_ready = 1;
    tick();                                   // handshake
    imem_rvalid = 1; imem_rdata = 32'h0000_000C;
    tick();
    imem_rvalid = 0;
    chk("t5_instrD", instrd,   32'h0000_000C);
    chk("t5_pc4D",   pcplus4d, 32'h0000_0000);
    chk("t5_pcwrap", pcf,      32'h0000_0000);

    // Test 6: async reset mid-fetch, late rvalid ignored
    tick();                                   // handshake -> S_WAIT
    tick();                                   // no response
`ifdef IF_FETCH_STALL_CNT_EN
    chk("t6_cnt", stat_cnt, 32'd2);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pc",     pcf,      32'hBFC0_0000);
    chk("t6_rst_ivalid", {31'b0, imem_valid}, 32'd0);
    chk("t6_rst_instrD", instrd,   32'h0);
    chk("t6_rst_pc4D",   pcplus4d, 32'h0);
    chk("t6_rst_validD", {31'b0, validd}, 32'd0);
`ifdef IF_FETCH_STALL_CNT_EN
    chk("t6_rst_cnt", stat_cnt, 32'd0);
`endif
    #1 rst_n = 1'b1;
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 0;
    chk("t6_late_validD", {31'b0, validd}, 32'd0);
    chk("t6_late_pc",     pcf, 32'hBFC0_0000);
    chk("t6_late_state",  32'(dut.state_q), 32'(S_REQ));
    chk("t6_late_ivalid", {31'b0, imem_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
